// File: rtl/kalman_timer_pkg.sv
// rtl/kalman_timer_pkg.sv - shared types, mode constants and priority helper for the Kalman phase timer
package kalman_timer_pkg;

    typedef enum logic [1:0] {KT_IDLE, KT_RUN, KT_DONE} kt_state_t;

    localparam int KT_MODE_ROLL  = 0;
    localparam int KT_MODE_PITCH = 1;
    localparam int KT_MODE_YAW   = 2;

    // Lowest set bit index of vec; 0 when vec is empty (callers only use it when non-empty).
    function automatic int unsigned kt_prio_first(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/kt_run_counter.sv
// rtl/kt_run_counter.sv - run-length latch and elapsed-cycle counter with last-cycle flag
module kt_run_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] len_in,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] len_q;

    // Latch the run length on load (0 behaves as 1) and count elapsed run cycles.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            len_q <= CNT_W'(1);
            count <= '0;
        end else if (load) begin
            len_q <= (len_in == '0) ? CNT_W'(1) : len_in;
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == (len_q - CNT_W'(1)));

endmodule

// File: rtl/kalman_phase_timer.sv
// rtl/kalman_phase_timer.sv - multi-mode phase timer top; optional overrun detection via KALMAN_TIMER_OVERRUN_EN
module kalman_phase_timer
    import kalman_timer_pkg::*;
#(
    parameter int NUM_MODES = 3,
    parameter int CNT_W     = 8,
    parameter int MODE_W    = $clog2(NUM_MODES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [NUM_MODES-1:0]       req,
    input  logic [NUM_MODES*CNT_W-1:0] cfg_len,
    output logic                       busy,
    output logic [MODE_W-1:0]          active_mode,
    output logic [CNT_W-1:0]           count_out,
    output logic [NUM_MODES-1:0]       pending,
    output logic                       kalman_done,
    output logic [MODE_W-1:0]          done_mode,
    output logic                       overrun
);

    kt_state_t              state, state_n;
    logic [NUM_MODES-1:0]   pending_q, pending_n, req_all;
    logic                   grant;
    logic                   last;
    logic [MODE_W-1:0]      winner, active_q;
    logic [CNT_W-1:0]       len_sel;

    assign req_all = pending_q | req;
    assign winner  = MODE_W'(kt_prio_first(32'(req_all)));
    assign len_sel = cfg_len[int'(winner)*CNT_W +: CNT_W];

    // State register; clear aborts everything back to idle.
    always_ff @(posedge clk) begin
        if (rst || clear) state <= KT_IDLE;
        else              state <= state_n;
    end

    // Next-state and grant decision.
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        case (state)
            KT_IDLE: begin
                if (req_all != '0) begin
                    grant   = 1'b1;
                    state_n = KT_RUN;
                end
            end
            KT_RUN: begin
                if (last) state_n = KT_DONE;
            end
            KT_DONE: begin
                if (pending_q != '0) begin
                    grant   = 1'b1;
                    state_n = KT_RUN;
                end else begin
                    state_n = KT_IDLE;
                end
            end
            default: state_n = KT_IDLE;
        endcase
    end

    // New requests accumulate; the granted mode's bit (including a same-cycle req) is consumed.
    always_comb begin
        pending_n = req_all;
        if (grant) pending_n[winner] = 1'b0;
    end

    // Pending bitmap register.
    always_ff @(posedge clk) begin
        if (rst || clear) pending_q <= '0;
        else              pending_q <= pending_n;
    end

    // Active mode follows each grant and is only forgotten on reset.
    always_ff @(posedge clk) begin
        if (rst)                  active_q <= '0;
        else if (grant && !clear) active_q <= winner;
    end

    kt_run_counter #(.CNT_W(CNT_W)) u_run_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .load   (grant),
        .enable ((state == KT_RUN) && !last),
        .len_in (len_sel),
        .count  (count_out),
        .last   (last)
    );

`ifdef KALMAN_TIMER_OVERRUN_EN
    logic overrun_q;

    // Sticky flag: a request arrived for a mode that was already pending.
    always_ff @(posedge clk) begin
        if (rst || clear)            overrun_q <= 1'b0;
        else if ((req & pending_q) != '0) overrun_q <= 1'b1;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign busy        = (state != KT_IDLE);
    assign active_mode = active_q;
    assign pending     = pending_q;
    assign kalman_done = (state == KT_DONE) && !clear;
    assign done_mode   = kalman_done ? active_q : '0;

endmodule

// File: tb/tb_kalman_phase_timer.sv
// tb/tb_kalman_phase_timer.sv - directed self-checking bench for kalman_phase_timer
module tb_kalman_phase_timer;

`ifdef KALMAN_TIMER_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        clear;
    logic [2:0]  req;
    logic [23:0] cfg_len;
    logic        busy;
    logic [1:0]  active_mode;
    logic [7:0]  count_out;
    logic [2:0]  pending;
    logic        kalman_done;
    logic [1:0]  done_mode;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    kalman_phase_timer dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .req         (req),
        .cfg_len     (cfg_len),
        .busy        (busy),
        .active_mode (active_mode),
        .count_out   (count_out),
        .pending     (pending),
        .kalman_done (kalman_done),
        .done_mode   (done_mode),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0; req = 3'b000;
        cfg_len = {8'd5, 8'd3, 8'd4};
        tick(); tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (count_out !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_out); end
        checks++; if (pending !== 3'b000) begin failures++; $display("FAIL reset_pending got=%b exp=000", pending); end
        checks++; if (kalman_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", kalman_done); end
        checks++; if (active_mode !== 2'd0) begin failures++; $display("FAIL reset_active got=%0d exp=0", active_mode); end
        checks++; if (done_mode !== 2'd0) begin failures++; $display("FAIL reset_done_mode got=%0d exp=0", done_mode); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    endtask

    task automatic test_single_run;
        req = 3'b001;
        tick();
        req = 3'b000;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0b exp=1", busy); end
        checks++; if (active_mode !== 2'd0) begin failures++; $display("FAIL single_active got=%0d exp=0", active_mode); end
        checks++; if (count_out !== 8'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", count_out); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (count_out !== 8'(i)) begin failures++; $display("FAIL single_count got=%0d exp=%0d", count_out, i); end
            checks++; if (kalman_done !== 1'b0) begin failures++; $display("FAIL single_early_done got=%0b exp=0 step=%0d", kalman_done, i); end
        end
        tick();
        checks++; if (kalman_done !== 1'b1) begin failures++; $display("FAIL single_done got=%0b exp=1", kalman_done); end
        checks++; if (done_mode !== 2'd0) begin failures++; $display("FAIL single_done_mode got=%0d exp=0", done_mode); end
        checks++; if (count_out !== 8'd3) begin failures++; $display("FAIL single_count_hold got=%0d exp=3", count_out); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b exp=0", busy); end
        checks++; if (kalman_done !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%0b exp=0", kalman_done); end
    endtask

    task automatic test_back_to_back;
        req = 3'b110;
        tick();
        req = 3'b000;
        checks++; if (active_mode !== 2'd1) begin failures++; $display("FAIL b2b_first_mode got=%0d exp=1", active_mode); end
        checks++; if (pending !== 3'b100) begin failures++; $display("FAIL b2b_pending got=%b exp=100", pending); end
        tick(); tick();
        checks++; if (count_out !== 8'd2) begin failures++; $display("FAIL b2b_pitch_count got=%0d exp=2", count_out); end
        tick();
        checks++; if (kalman_done !== 1'b1 || done_mode !== 2'd1) begin failures++; $display("FAIL b2b_done1 got=%0b/%0d exp=1/1", kalman_done, done_mode); end
        checks++; if (pending !== 3'b100) begin failures++; $display("FAIL b2b_pending_done got=%b exp=100", pending); end
        tick();
        checks++; if (busy !== 1'b1 || active_mode !== 2'd2 || count_out !== 8'd0) begin failures++; $display("FAIL b2b_yaw_start got=%0b/%0d/%0d exp=1/2/0", busy, active_mode, count_out); end
        checks++; if (pending !== 3'b000) begin failures++; $display("FAIL b2b_pending_empty got=%b exp=000", pending); end
        tick(); tick(); tick(); tick();
        checks++; if (count_out !== 8'd4 || kalman_done !== 1'b0) begin failures++; $display("FAIL b2b_yaw_last got=%0d/%0b exp=4/0", count_out, kalman_done); end
        tick();
        checks++; if (kalman_done !== 1'b1 || done_mode !== 2'd2) begin failures++; $display("FAIL b2b_done2 got=%0b/%0d exp=1/2", kalman_done, done_mode); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_len_edges;
        cfg_len = {8'd5, 8'd3, 8'd0};
        req = 3'b001;
        tick();
        req = 3'b000;
        checks++; if (busy !== 1'b1 || kalman_done !== 1'b0) begin failures++; $display("FAIL len0_run got=%0b/%0b exp=1/0", busy, kalman_done); end
        tick();
        checks++; if (kalman_done !== 1'b1 || done_mode !== 2'd0) begin failures++; $display("FAIL len0_done got=%0b/%0d exp=1/0", kalman_done, done_mode); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL len0_idle got=%0b exp=0", busy); end
        cfg_len = {8'd5, 8'd3, 8'd4};
        req = 3'b001;
        tick();
        req = 3'b000;
        cfg_len = {8'd1, 8'd1, 8'd1};
        tick(); tick(); tick();
        checks++; if (count_out !== 8'd3 || kalman_done !== 1'b0) begin failures++; $display("FAIL cfg_change_run got=%0d/%0b exp=3/0", count_out, kalman_done); end
        tick();
        checks++; if (kalman_done !== 1'b1) begin failures++; $display("FAIL cfg_change_done got=%0b exp=1", kalman_done); end
        tick();
        cfg_len = {8'd5, 8'd3, 8'd4};
    endtask

    task automatic test_clear;
        req = 3'b100;
        tick();
        req = 3'b000;
        tick(); tick();
        checks++; if (count_out !== 8'd2) begin failures++; $display("FAIL clr_run_count got=%0d exp=2", count_out); end
        clear = 1'b1; req = 3'b001;
        #1;
        checks++; if (kalman_done !== 1'b0) begin failures++; $display("FAIL clr_run_nodone got=%0b exp=0", kalman_done); end
        tick();
        clear = 1'b0; req = 3'b000;
        checks++; if (busy !== 1'b0 || pending !== 3'b000 || count_out !== 8'd0) begin failures++; $display("FAIL clr_run_state got=%0b/%b/%0d exp=0/000/0", busy, pending, count_out); end
        tick();
        checks++; if (busy !== 1'b0 || pending !== 3'b000) begin failures++; $display("FAIL clr_req_dropped got=%0b/%b exp=0/000", busy, pending); end
        req = 3'b010;
        tick();
        req = 3'b100;
        tick();
        req = 3'b000;
        tick(); tick();
        checks++; if (pending !== 3'b100 || busy !== 1'b1) begin failures++; $display("FAIL clr_done_setup got=%b/%0b exp=100/1", pending, busy); end
        clear = 1'b1;
        #1;
        checks++; if (kalman_done !== 1'b0) begin failures++; $display("FAIL clr_done_nopulse got=%0b exp=0", kalman_done); end
        tick();
        clear = 1'b0;
        checks++; if (busy !== 1'b0 || pending !== 3'b000 || count_out !== 8'd0) begin failures++; $display("FAIL clr_done_state got=%0b/%b/%0d exp=0/000/0", busy, pending, count_out); end
        tick();
        checks++; if (busy !== 1'b0 || kalman_done !== 1'b0) begin failures++; $display("FAIL clr_done_after got=%0b/%0b exp=0/0", busy, kalman_done); end
    endtask

    task automatic test_overrun;
        req = 3'b100;
        tick();
        req = 3'b001;
        tick();
        checks++; if (pending !== 3'b001 || overrun !== 1'b0) begin failures++; $display("FAIL ovr_first got=%b/%0b exp=001/0", pending, overrun); end
        tick();
        req = 3'b000;
        checks++; if (overrun !== OVR_EN) begin failures++; $display("FAIL ovr_set got=%0b exp=%0b", overrun, OVR_EN); end
        checks++; if (pending !== 3'b001) begin failures++; $display("FAIL ovr_pending got=%b exp=001", pending); end
        tick();
        checks++; if (overrun !== OVR_EN) begin failures++; $display("FAIL ovr_sticky got=%0b exp=%0b", overrun, OVR_EN); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (overrun !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ovr_cleared got=%0b/%0b exp=0/0", overrun, busy); end
    endtask

    task automatic test_rst_midrun;
        req = 3'b100;
        tick();
        req = 3'b110;
        tick();
        req = 3'b000;
        checks++; if (pending !== 3'b110 || active_mode !== 2'd2) begin failures++; $display("FAIL rst_setup got=%b/%0d exp=110/2", pending, active_mode); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || active_mode !== 2'd0 || count_out !== 8'd0) begin failures++; $display("FAIL rst_mid_core got=%0b/%0d/%0d exp=0/0/0", busy, active_mode, count_out); end
        checks++; if (pending !== 3'b000 || kalman_done !== 1'b0 || done_mode !== 2'd0 || overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b/%0b/%0d/%0b exp=000/0/0/0", pending, kalman_done, done_mode, overrun); end
        req = 3'b010;
        tick();
        req = 3'b000;
        checks++; if (busy !== 1'b1 || active_mode !== 2'd1 || count_out !== 8'd0) begin failures++; $display("FAIL rst_after_start got=%0b/%0d/%0d exp=1/1/0", busy, active_mode, count_out); end
        tick(); tick(); tick();
        checks++; if (kalman_done !== 1'b1 || done_mode !== 2'd1) begin failures++; $display("FAIL rst_after_done got=%0b/%0d exp=1/1", kalman_done, done_mode); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_after_idle got=%0b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_back_to_back();
        test_len_edges();
        test_clear();
        test_overrun();
        test_rst_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
